// File: rtl/iopmp_ahb_cfg_slave_pkg.sv
// iopmp_ahb_cfg_slave_pkg: register map, AHB encodings, FSM states and exception record type
package iopmp_ahb_cfg_slave_pkg;
    localparam logic [31:0] IOPMP_WRITE_ADDR = 32'h1000_0000;
    localparam logic [31:0] IOPMP_EXP_ADDR = 32'h1000_0004;
    localparam logic [1:0] HTRANS_IDLE = 2'b00;
    localparam logic [1:0] HTRANS_BUSY = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ = 2'b11;
    localparam logic [1:0] HRESP_OKAY = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;
    localparam logic [2:0] HSIZE_WORD = 3'b010;
    typedef enum logic [2:0] {IDLE, DATA, WAIT_FULL, ERR1, ERR2} slv_state_e;
    typedef struct packed {
        logic valid;
        logic overflow;
        logic [29:0] info;
    } exc_rec_t;
endpackage

// File: rtl/iopmp_ahb_cfg_slave_if.sv
// iopmp_ahb_cfg_slave_if: AHB-lite slave port of the slave-9 router branch
interface iopmp_ahb_cfg_slave_if;
    logic [3:0] hprot;
    logic [2:0] hsize;
    logic [1:0] htrans;
    logic [31:0] hwdata;
    logic hwrite;
    logic [31:0] haddr;
    logic [31:0] hrdata;
    logic hready;
    logic [1:0] hresp;
    modport master (output hprot, hsize, htrans, hwdata, hwrite, haddr, input hrdata, hready, hresp);
    modport slave (input hprot, hsize, htrans, hwdata, hwrite, haddr, output hrdata, hready, hresp);
endinterface

// File: rtl/iopmp_ahb_cfg_slave_fifo.sv
// iopmp_ahb_cfg_slave_fifo: first-word-fall-through config FIFO with wrap-bit pointers
module iopmp_ahb_cfg_slave_fifo #(
    parameter int DEPTH = 4,
    parameter int W = 32
) (
    input logic clk,
    input logic reset,
    input logic push,
    input logic pop,
    input logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic full,
    output logic empty
);
    localparam int AW = $clog2(DEPTH);
    logic [AW:0] wp, rp;
    logic [W-1:0] mem [DEPTH];
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wp <= '0;
            rp <= '0;
        end else begin
            wp <= wp + (AW+1)'(push);
            rp <= rp + (AW+1)'(pop);
        end
    end
    always_ff @(posedge clk) begin
        if (push) mem[wp[AW-1:0]] <= din;
    end
    assign dout = mem[rp[AW-1:0]];
    assign empty = wp == rp;
    assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
endmodule

// File: rtl/iopmp_ahb_cfg_slave.sv
// iopmp_ahb_cfg_slave: AHB-lite config slave feeding the IOPMP config FIFO and exposing the exception record
module iopmp_ahb_cfg_slave
    import iopmp_ahb_cfg_slave_pkg::*;
#(
    parameter int CFG_DEPTH = 4
) (
    input logic clk,
    input logic reset,
    iopmp_ahb_cfg_slave_if.slave ahb,
    output logic cfg_valid_o,
    output logic [31:0] cfg_data_o,
    input logic cfg_ready_i,
    input logic exc_valid_i,
    input logic [29:0] exc_info_i,
    output logic exc_irq_o
);
    slv_state_e state, state_n;
    exc_rec_t rec;
    logic a_write, full, empty, push, pop, push_ok, addr_ph, legal, wr_phase, rd_clr;
    logic unused_ok;
    assign unused_ok = ^ahb.hprot;
    assign pop = !empty && cfg_ready_i;
    assign push_ok = !full || pop;
    assign wr_phase = (state == DATA || state == WAIT_FULL) && a_write;
    assign push = wr_phase && push_ok;
    assign rd_clr = state == DATA && !a_write;
    assign addr_ph = ahb.hready && ahb.htrans[1];
    assign legal = ahb.hsize == HSIZE_WORD &&
                   (ahb.hwrite ? ahb.haddr == IOPMP_WRITE_ADDR : ahb.haddr == IOPMP_EXP_ADDR);
    assign ahb.hready = state == ERR1 ? 1'b0 : wr_phase ? push_ok : 1'b1;
    assign ahb.hresp = (state == ERR1 || state == ERR2) ? HRESP_ERROR : HRESP_OKAY;
    assign ahb.hrdata = rd_clr ? rec : '0;
    assign cfg_valid_o = !empty;
    assign exc_irq_o = rec.valid;
    // a stalled write is the only way hready drops outside ERR1
    always_comb begin
        state_n = state == ERR1 ? ERR2 : !ahb.hready ? WAIT_FULL : !addr_ph ? IDLE : legal ? DATA : ERR1;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            a_write <= 1'b0;
        end else begin
            state <= state_n;
            if (addr_ph) a_write <= ahb.hwrite;
        end
    end
    // a read-clear and a new violation in the same cycle start a fresh record
    always_ff @(posedge clk or posedge reset) begin
        if (reset) rec <= '0;
        else if (rd_clr) rec <= '{valid: exc_valid_i, overflow: 1'b0, info: exc_valid_i ? exc_info_i : 30'd0};
        else if (exc_valid_i) rec <= rec.valid ? '{valid: 1'b1, overflow: 1'b1, info: rec.info}
                                               : '{valid: 1'b1, overflow: 1'b0, info: exc_info_i};
    end
    iopmp_ahb_cfg_slave_fifo #(.DEPTH(CFG_DEPTH), .W(32)) u_fifo (
        .clk(clk),
        .reset(reset),
        .push(push),
        .pop(pop),
        .din(ahb.hwdata),
        .dout(cfg_data_o),
        .full(full),
        .empty(empty)
    );
endmodule
